// File: rtl/sram_frame_reader_pkg.sv
// sram_frame_reader_pkg: shared widths and FSM encoding for the SRAM frame reader
//   PIX_W / WORD_W / SRAM_ADDR_W / PIX_PER_WORD: pixel, SRAM word and address geometry
//   state_t: reader FSM states
package sram_frame_reader_pkg;
    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int SRAM_ADDR_W  = 18;
    localparam int PIX_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sram_frame_reader_if.sv
// sram_frame_reader_if: frame control, SRAM R1 port and pixel stream bundle
//   start/start_ack, done/done_ack : frame-level handshake
//   addr/addr_valid/addr_ready     : word address request to arbiter R1
//   data/data_valid/data_ready     : word response from arbiter R1
//   pixel/pixel_valid/pixel_ready  : 8-bit pixel output stream
//   master = reader side, slave = environment side
interface sram_frame_reader_if;
    import sram_frame_reader_pkg::*;
    logic                   start, start_ack, done, done_ack;
    logic [SRAM_ADDR_W-1:0] addr;
    logic                   addr_valid, addr_ready;
    logic [WORD_W-1:0]      data;
    logic                   data_valid, data_ready;
    logic [PIX_W-1:0]       pixel;
    logic                   pixel_valid, pixel_ready;
    modport master (
        input  start, done_ack, addr_ready, data, data_valid, pixel_ready,
        output start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid
    );
    modport slave (
        output start, done_ack, addr_ready, data, data_valid, pixel_ready,
        input  start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid
    );
endinterface

// File: rtl/sram_frame_reader_fifo.sv
// frame_reader_fifo: synchronous response FIFO, W x DEPTH (DEPTH power of 2)
//   clock, reset      : clock, asynchronous active-high reset
//   push/wr_data      : write request and word
//   pop/rd_data       : read request and head word (first-word fall-through)
//   count/full/empty  : occupancy status
module frame_reader_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rd_en   = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign wr_en   = push && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock)
        if (wr_en) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/sram_frame_reader.sv
// sram_frame_reader: reads one packed grayscale frame from SRAM R1 and emits it as a pixel stream
//   clock, reset : single clock, asynchronous active-high reset
//   bus          : sram_frame_reader_if master (frame handshake, R1 request/response, pixel stream)
module sram_frame_reader
    import sram_frame_reader_pkg::*;
#(
    parameter int                     N_PIXEL    = 480000,
    parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                     FIFO_DEPTH = 8
) (
    input logic                 clock,
    input logic                 reset,
    sram_frame_reader_if.master bus
);
    localparam int N_WORD = N_PIXEL / PIX_PER_WORD;
    localparam int RW     = $clog2(N_WORD + 1);
    localparam int PW     = $clog2(N_PIXEL);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    state_t            state, next_state;
    logic [RW-1:0]     req_cnt;
    logic [PW-1:0]     pix_cnt;
    logic [CW-1:0]     in_flight, fifo_count;
    logic [1:0]        byte_sel;
    logic [WORD_W-1:0] head;
    logic              fifo_full, fifo_empty;
    logic              credit_ok, addr_hs, push, load, pop, pix_hs;

    // words in flight plus words buffered never exceed FIFO capacity
    assign credit_ok = !fifo_full && (fifo_count + in_flight) < CW'(FIFO_DEPTH);
    assign addr_hs   = bus.addr_valid && bus.addr_ready;
    // responses nobody asked for are dropped without touching any counter
    assign push      = bus.data_valid && state != IDLE && in_flight != '0;
    assign load      = !fifo_empty && (!bus.pixel_valid || bus.pixel_ready);
    assign pop       = load && byte_sel == 2'(PIX_PER_WORD - 1);
    assign pix_hs    = bus.pixel_valid && bus.pixel_ready;

    assign bus.addr       = BASE_ADDR + SRAM_ADDR_W'(req_cnt);
    assign bus.data_ready = 1'b1;

    frame_reader_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.data),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = bus.start ? RUN : IDLE;
            RUN:     next_state = (addr_hs && req_cnt == RW'(N_WORD - 1)) ? DRAIN : RUN;
            DRAIN:   next_state = (pix_hs && pix_cnt == PW'(N_PIXEL - 1)) ? DONE : DRAIN;
            DONE:    next_state = bus.done_ack ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.start_ack  = state == IDLE && bus.start;
        bus.done       = state == DONE;
        bus.addr_valid = state == RUN && credit_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_cnt         <= '0;
            pix_cnt         <= '0;
            in_flight       <= '0;
            byte_sel        <= '0;
            bus.pixel       <= '0;
            bus.pixel_valid <= 1'b0;
        end else begin
            req_cnt   <= bus.start_ack ? '0 : req_cnt + RW'(addr_hs);
            pix_cnt   <= bus.start_ack ? '0 : pix_cnt + PW'(pix_hs);
            in_flight <= in_flight + CW'(addr_hs) - CW'(push);
            // output register refills from the FIFO head every accepted cycle, LSB byte first
            if (load) begin
                bus.pixel       <= PIX_W'(head >> {byte_sel, 3'b000});
                bus.pixel_valid <= 1'b1;
                byte_sel        <= byte_sel + 2'd1;
            end else if (bus.pixel_ready) begin
                bus.pixel_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader: directed table-driven bench with arbiter model and pixel scoreboard
module tb_sram_frame_reader;
    import sram_frame_reader_pkg::*;

    localparam int          NP    = 32;
    localparam int          DEPTH = 4;
    localparam logic [17:0] BASE  = 18'h3FFFE;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rsp_t;

    typedef struct {
        int          lat;
        bit          rnd;
        int          ack_dly;
        int          exp_words;
        int          exp_pix;
        int          min_q;
        logic [17:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_frame_reader_if bus();

    sram_frame_reader #(.N_PIXEL(NP), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    rsp_t        q[$];
    int          checks, errors, cyc, lat, stray_n, sa_cnt, cyc_sa, n_addr, pix_exp;
    int          first_av, first_d, first_pv, max_q;
    bit          pr_rand, ovf, stalled, last_prev;
    logic [7:0]  stall_pix;
    logic [17:0] last_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(int i);
        logic [17:0] a;
        logic [31:0] w;
        a = BASE + 18'(i / 4);
        w = 32'(a) * 32'd3;
        return w[8*(i%4) +: 8];
    endfunction

    // arbiter model + monitors: drive at negedge, sample 1 time unit later
    initial begin
        logic [17:0] ea;
        bus.data_valid  = 1'b0;
        bus.data        = '0;
        bus.pixel_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0 && q[0].due <= cyc) begin
                bus.data_valid = 1'b1;
                bus.data       = q[0].d;
                void'(q.pop_front());
                if (first_d < 0) first_d = cyc;
            end else if (stray_n > 0) begin
                bus.data_valid = 1'b1;
                bus.data       = 32'hDEADBEEF;
                stray_n--;
            end else begin
                bus.data_valid = 1'b0;
                bus.data       = '0;
            end
            bus.pixel_ready = pr_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
            #1;
            if (bus.start_ack) begin
                sa_cnt++;
                cyc_sa   = cyc;
                pix_exp  = 0;
                n_addr   = 0;
                first_av = -1;
                first_d  = -1;
                first_pv = -1;
                max_q    = 0;
                ovf      = 1'b0;
            end
            if (bus.addr_valid && first_av < 0) first_av = cyc;
            if (bus.pixel_valid && first_pv < 0) first_pv = cyc;
            if (bus.addr_valid && bus.addr_ready) begin
                ea = BASE + 18'(n_addr);
                chk("addr", 32'(bus.addr), 32'(ea));
                q.push_back('{32'(ea) * 32'd3, cyc + lat});
                last_addr = bus.addr;
                n_addr++;
            end
            if (q.size() > max_q) max_q = q.size();
            if (n_addr - pix_exp / 4 > DEPTH + 1) ovf = 1'b1;
            if (stalled) chk("stall_hold", {23'd0, bus.pixel_valid, bus.pixel}, {23'd0, 1'b1, stall_pix});
            stalled   = bus.pixel_valid && !bus.pixel_ready;
            stall_pix = bus.pixel;
            if (last_prev) chk("done_after_last", 32'(bus.done), 32'd1);
            last_prev = 1'b0;
            if (bus.pixel_valid && bus.pixel_ready) begin
                chk("pixel", 32'(bus.pixel), 32'(exp_pix(pix_exp)));
                if (pix_exp == NP - 1) begin
                    chk("done_before_last", 32'(bus.done), 32'd0);
                    last_prev = 1'b1;
                end
                pix_exp++;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_start_ack", 32'(bus.start_ack), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'(BASE));
        chk("rst_data_ready", 32'(bus.data_ready), 32'd1);
        chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("rst_pixel", 32'(bus.pixel), 32'd0);
    endtask

    task automatic start_frame(bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        #2;
        chk("start_ack", 32'(bus.start_ack), 32'd1);
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic finish_frame(int ack_dly, int sa0);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            #2;
            if (bus.done) break;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        repeat (ack_dly) @(negedge clk);
        @(negedge clk);
        #2;
        chk("done_held", 32'(bus.done), 32'd1);
        chk("one_start_ack", 32'(sa_cnt - sa0), 32'd1);
        @(negedge clk);
        bus.done_ack = 1'b1;
        @(negedge clk);
        bus.done_ack = 1'b0;
        #2;
        chk("done_clear", 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   sa0;
        vecs[0] = '{2,  1'b0, 0, 8, NP, 1, 18'h00005};
        vecs[1] = '{20, 1'b0, 3, 8, NP, 4, 18'h00005};
        vecs[2] = '{2,  1'b1, 1, 8, NP, 1, 18'h00005};
        vecs[3] = '{20, 1'b1, 0, 8, NP, 4, 18'h00005};
        first_av = -1;
        first_d  = -1;
        first_pv = -1;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.done_ack   = 1'b0;
        bus.addr_ready = 1'b1;
        lat            = 2;
        repeat (2) @(negedge clk);
        #2;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            lat     = vecs[i].lat;
            pr_rand = vecs[i].rnd;
            sa0     = sa_cnt;
            start_frame(1'b0);
            finish_frame(vecs[i].ack_dly, sa0);
            chk("words", 32'(n_addr), 32'(vecs[i].exp_words));
            chk("pixels", 32'(pix_exp), 32'(vecs[i].exp_pix));
            chk("last_addr", 32'(last_addr), 32'(vecs[i].exp_last));
            chk("first_req_lat", 32'(first_av - cyc_sa), 32'd1);
            chk("pix_lat_le2", 32'((first_pv - first_d) >= 1 && (first_pv - first_d) <= 2), 32'd1);
            chk("inflight_max", 32'(max_q <= DEPTH), 32'd1);
            chk("credit_sat", 32'(max_q >= vecs[i].min_q), 32'd1);
            chk("no_overflow", 32'(ovf), 32'd0);
        end

        // reset mid-frame, then stray responses in IDLE, then a fresh frame
        lat     = 2;
        pr_rand = 1'b0;
        start_frame(1'b0);
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            #2;
            if (pix_exp >= 5) break;
        end
        chk("five_pixels", 32'(pix_exp), 32'd5);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        stray_n = 3;
        repeat (6) @(negedge clk);
        #2;
        chk("stray_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("stray_addr_valid", 32'(bus.addr_valid), 32'd0);
        sa0 = sa_cnt;
        start_frame(1'b0);
        finish_frame(0, sa0);
        chk("fresh_words", 32'(n_addr), 32'd8);
        chk("fresh_pixels", 32'(pix_exp), 32'(NP));

        // start held high through DONE: one ack per frame, restart only from IDLE
        sa0 = sa_cnt;
        start_frame(1'b1);
        finish_frame(10, sa0);
        chk("restart_from_idle", 32'(bus.start_ack), 32'd1);
        chk("second_frame_ack", 32'(sa_cnt - sa0), 32'd2);
        @(negedge clk);
        bus.start = 1'b0;
        finish_frame(0, sa0 + 1);
        chk("frame2_pixels", 32'(pix_exp), 32'(NP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
